alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised multi-cycle ALU for the RV32 datapath. Adds SRA and the unsigned
//  M-extension ops (MUL, MULHU, DIVU, REMU) to the base integer ops.
//  Sits between the register-file read stage and write-back.
//  A valid/ready handshake lets the control FSM stall while an iterative op runs.
// PARAMETERS
//  WIDTH  32  operand/result width; must be >=4 and a power of two
//  (local) SHAMT_W = $clog2(WIDTH), shift-amount bits taken from B_i[SHAMT_W-1:0]
// PORTS
//  clk              in   1      rising-edge clock
//  reset            in   1      asynchronous, active-high reset
//  valid_i          in   1      request; op accepted when valid_i & ready_o at a clk edge
//  ALU_Operation_i  in   4      opcode, sampled on acceptance
//  A_i              in   WIDTH  operand A, sampled on acceptance
//  B_i              in   WIDTH  operand B, sampled on acceptance
//  ready_o          out  1      1 in IDLE and DONE states
//  done_o           out  1      one-cycle pulse: result_o/zero_o/carry_o/illegal_o valid
//  result_o         out  WIDTH  registered result; held until the next done_o
//  zero_o           out  1      result_o == 0, registered with result_o
//  carry_o          out  1      carry out of bit WIDTH-1 for ADD/SUB; 0 for all other ops
//  illegal_o        out  1      opcode not in the table below; registered with result_o
// BEHAVIOUR
//  Opcodes:
//   ADD 0000 | SUB 1000 | SLL 0001 | SRL 0101 | SRA 1101 | XOR 0100 | OR 0110 | AND 0111
//   MUL 0010 (low WIDTH bits of A*B) | MULHU 0011 (high WIDTH bits, unsigned)
//   DIVU 1010 | REMU 1011
//  Arithmetic:
//   - ADD and SUB are computed on WIDTH+1 bits. SUB = A + ~B + 1, so carry_o=1 means no borrow.
//   - Shifts use only B_i[SHAMT_W-1:0]. SRA replicates A[WIDTH-1].
//  Fast ops (ADD through AND, illegal opcodes, and DIVU/REMU with B==0) have 1-cycle latency.
//   - Accepted at edge E, done_o is high in the cycle after E.
//  Iterative ops (MUL, MULHU, DIVU/REMU with B!=0) take WIDTH cycles.
//   - MUL/MULHU: one shift-add step per cycle over a 2*WIDTH-bit product register.
//   - DIVU/REMU: one restoring shift-subtract step per cycle.
//   - done_o is high exactly WIDTH+1 cycles after the accepting edge.
//  Divide by zero: DIVU gives all-ones, REMU gives A. No trap and no flag.
//  Illegal opcode: result_o=0, zero_o=1, carry_o=0, illegal_o=1. Completes as a fast op.
//  State machine:
//   - IDLE --accept fast--> DONE; IDLE --accept iterative--> RUN (cnt=WIDTH-1).
//   - RUN: one step per cycle, cnt decrements; on the step with cnt==0 -> DONE.
//   - DONE (done_o=1): accept fast -> DONE, accept iterative -> RUN, otherwise -> IDLE.
//  Handshake rules:
//   - Back-to-back ops are allowed: a new op may be accepted in the DONE cycle.
//   - valid_i is ignored in RUN; operands and opcode are not resampled there.
//   - Input changes after acceptance have no effect.
//   - result_o, zero_o, carry_o and illegal_o update only on the edge entering DONE.
//     They hold otherwise, including in IDLE.
//  Reset (any time, including mid-RUN):
//   - state=IDLE, cnt=0, done_o=0, result_o=0, zero_o=0, carry_o=0, illegal_o=0, ready_o=1.
//   - An in-flight op is discarded; no done_o is produced for it.
//   - Inputs are ignored while reset is high.
// TESTING
//  1. ADD A=FFFFFFFF B=00000001 -> next cycle: done_o=1, result=0, zero=1, carry=1.
//     SUB 5-7 -> FFFFFFFE, carry=0.
//  2. SRA A=80000000 B=24 (shamt 4) -> F8000000.
//     SRL same operands -> 08000000; SLL A=1 B=FFFFFFFF -> 80000000.
//  3. MUL A=00010000 B=00010000 -> result 0, zero=1.
//     MULHU same operands -> 00000001. done_o exactly 33 cycles after accept; ready_o=0 in between.
//  4. DIVU 100/7 -> 14; REMU 100/7 -> 2 (33 cycles each).
//     DIVU 123/0 -> FFFFFFFF and REMU 123/0 -> 123, each with done_o 1 cycle after accept.
//  5. Accept MUL, toggle valid_i/A_i/B_i during RUN -> original product returned.
//     Assert reset at RUN cycle 10 -> no done_o; outputs 0; ready_o=1; a following ADD works.
//  6. Opcode 1111 -> done_o next cycle, illegal_o=1, result 0.
//     Accept ADD in that DONE cycle -> done_o high two consecutive cycles.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle RV32 ALU: single-cycle base ops plus iterative unsigned multiply/divide.
// Handshake: an op is accepted on a clk edge where valid_i & ready_o; done_o pulses for one cycle when outputs are fresh.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             illegal_o,
  output logic [1:0]       state_dbg
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_MULHU = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               state;
  logic [SHAMT_W-1:0]   cnt;
  logic [3:0]           op_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   acc;

  logic [WIDTH:0]       add_sum, sub_sum;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     fast_res;
  logic                 fast_carry, fast_ill, iter;

  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, step_next;
  logic [WIDTH-1:0]     step_res;

  always_comb begin
    add_sum    = {1'b0, A_i} + {1'b0, B_i};
    sub_sum    = {1'b0, A_i} + {1'b0, ~B_i} + {{WIDTH{1'b0}}, 1'b1};
    shamt      = B_i[SHAMT_W-1:0];
    fast_res   = '0;
    fast_carry = 1'b0;
    fast_ill   = 1'b0;
    iter       = 1'b0;
    case (ALU_Operation_i)
      OP_ADD:   begin fast_res = add_sum[WIDTH-1:0]; fast_carry = add_sum[WIDTH]; end
      OP_SUB:   begin fast_res = sub_sum[WIDTH-1:0]; fast_carry = sub_sum[WIDTH]; end
      OP_SLL:   fast_res = A_i << shamt;
      OP_SRL:   fast_res = A_i >> shamt;
      OP_SRA:   fast_res = $signed(A_i) >>> shamt;
      OP_XOR:   fast_res = A_i ^ B_i;
      OP_OR:    fast_res = A_i | B_i;
      OP_AND:   fast_res = A_i & B_i;
      OP_MUL, OP_MULHU: iter = 1'b1;
      OP_DIVU:  if (B_i == '0) fast_res = '1;  else iter = 1'b1;
      OP_REMU:  if (B_i == '0) fast_res = A_i; else iter = 1'b1;
      default:  fast_ill = 1'b1;
    endcase
  end

  // acc = {hi, lo}: multiply keeps {partial product, multiplier}; divide keeps {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_r};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    step_next = op_r[3] ? div_next : mul_next;
    // MULHU and REMU take the high half, MUL and DIVU the low half.
    step_res  = op_r[0] ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_r      <= '0;
      b_r       <= '0;
      acc       <= '0;
      result_o  <= '0;
      zero_o    <= 1'b0;
      carry_o   <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (valid_i) begin
            if (iter) begin
              state <= RUN;
              cnt   <= SHAMT_W'(WIDTH - 1);
              op_r  <= ALU_Operation_i;
              b_r   <= B_i;
              acc   <= {{WIDTH{1'b0}}, A_i};
            end else begin
              state     <= DONE;
              result_o  <= fast_res;
              zero_o    <= (fast_res == '0);
              carry_o   <= fast_carry;
              illegal_o <= fast_ill;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= step_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            result_o  <= step_res;
            zero_o    <= (step_res == '0);
            carry_o   <= 1'b0;
            illegal_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o   = (state != RUN);
  assign done_o    = (state == DONE);
  assign state_dbg = state;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: hand-computed vectors, latency, handshake and reset cases.
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         ready, done, zero, carry, illegal;
  logic [W-1:0] result;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .valid_i(valid), .ALU_Operation_i(op),
    .A_i(a), .B_i(b), .ready_o(ready), .done_o(done), .result_o(result),
    .zero_o(zero), .carry_o(carry), .illegal_o(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, wait for done_o, check latency (in negedges after the accepting edge) and outputs.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_res,
                        input logic exp_carry, input logic exp_ill, input int exp_lat);
    int lat;
    logic ready_bad;
    lat = 0;
    ready_bad = 1'b0;
    @(negedge clk);
    valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (ready) ready_bad = 1'b1;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_zero"}, zero, (exp_res == '0));
    check({tag, "_carry"}, carry, exp_carry);
    check({tag, "_ill"}, illegal, exp_ill);
    if (exp_lat > 1) check({tag, "_ready_run"}, ready_bad, 1'b0);
  endtask

  initial begin
    int lat;
    logic seen;
    reset = 1'b1; valid = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;

    run_op("add",   4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1);
    run_op("sub",   4'b1000, 32'd5,         32'd7,         32'hFFFF_FFFE, 0, 0, 1);
    run_op("sra",   4'b1101, 32'h8000_0000, 32'd36,        32'hF800_0000, 0, 0, 1);
    run_op("srl",   4'b0101, 32'h8000_0000, 32'd36,        32'h0800_0000, 0, 0, 1);
    run_op("sll",   4'b0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 1);
    run_op("xor",   4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 0, 0, 1);
    run_op("or",    4'b0110, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 0, 0, 1);
    run_op("and",   4'b0111, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00, 0, 0, 1);
    run_op("mul",   4'b0010, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0, 0, 33);
    run_op("mulhu", 4'b0011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0, 0, 33);
    run_op("divu",  4'b1010, 32'd100,       32'd7,         32'd14,        0, 0, 33);
    run_op("remu",  4'b1011, 32'd100,       32'd7,         32'd2,         0, 0, 33);
    run_op("divu0", 4'b1010, 32'd123,       32'd0,         32'hFFFF_FFFF, 0, 0, 1);
    run_op("remu0", 4'b1011, 32'd123,       32'd0,         32'd123,       0, 0, 1);

    // Outputs hold in IDLE
    repeat (3) @(negedge clk);
    check("hold_done", done, 0);
    check("hold_res", result, 32'd123);

    // Inputs wiggled during RUN must not disturb the product
    @(negedge clk);
    valid = 1'b1; op = 4'b0010; a = 32'h0000_1234; b = 32'h0000_0010;
    @(posedge clk);
    #1;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (i < 20) begin
        valid = 1'b1; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
      end else begin
        valid = 1'b0;
      end
    end
    valid = 1'b0;
    check("toggle_lat", lat, 33);
    check("toggle_res", result, 32'h0001_2340);

    // Reset in the middle of RUN discards the op
    @(negedge clk);
    valid = 1'b1; op = 4'b0010; a = 32'd5; b = 32'd6;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mrst_done", done, 0);
    check("mrst_ready", ready, 1);
    check("mrst_result", result, 0);
    check("mrst_zero", zero, 0);
    check("mrst_carry", carry, 0);
    check("mrst_ill", illegal, 0);
    check("mrst_state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("mrst_no_done", seen, 0);
    run_op("add_after_rst", 4'b0000, 32'd2, 32'd2, 32'd4, 0, 0, 1);

    // Illegal opcode, then a back-to-back ADD accepted in its DONE cycle
    @(negedge clk);
    valid = 1'b1; op = 4'b1111; a = 32'h55; b = 32'hAA;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check("ill_done", done, 1);
    check("ill_flag", illegal, 1);
    check("ill_res", result, 0);
    check("ill_zero", zero, 1);
    check("ill_carry", carry, 0);
    check("b2b_ready", ready, 1);
    valid = 1'b1; op = 4'b0000; a = 32'd3; b = 32'd4;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check("b2b_done", done, 1);
    check("b2b_res", result, 32'd7);
    check("b2b_ill", illegal, 0);
    @(negedge clk);
    check("b2b_done_end", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
